// File: rtl/pattern_locater.sv
// rtl/pattern_locater.sv - serial frame-sync pattern locator with frame position and match sequence
module pattern_locater #(
    parameter logic [3:0] PATTERN   = 4'b1110,
    parameter int         FRAME_LEN = 20
) (
    input  logic       CLK,
    input  logic       SCLR,
    input  logic       IN_DATA,
    output logic       PDET,
    output logic [4:0] LOC,
    output logic [1:0] SEQ
);

    localparam logic [4:0] LAST_POS = 5'(FRAME_LEN - 1);

    logic [3:0] sr;
    logic [4:0] pos;
    logic [1:0] fill;
    logic [3:0] window;
    logic       match;

    // fill reaching 3 means three earlier bits exist, so the incoming bit completes a real window
    always_comb begin
        window = {sr[2:0], IN_DATA};
        match  = (window == PATTERN) && (fill == 2'd3);
    end

    always_ff @(posedge CLK) begin
        if (SCLR) begin
            sr   <= 4'd0;
            pos  <= 5'd0;
            fill <= 2'd0;
            PDET <= 1'b0;
            LOC  <= 5'd0;
            SEQ  <= 2'd0;
        end else begin
            sr   <= window;
            pos  <= (pos == LAST_POS) ? 5'd0 : pos + 5'd1;
            if (fill != 2'd3) begin
                fill <= fill + 2'd1;
            end
            PDET <= match;
            if (match) begin
                LOC <= pos;
                SEQ <= SEQ + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_locater.sv
// tb/tb_pattern_locater.sv - scoreboard bench for pattern_locater against a bit-history model
module tb_pattern_locater;

    localparam logic [3:0] P0 = 4'b1110;
    localparam int         L0 = 20;
    localparam logic [3:0] P1 = 4'b0000;
    localparam int         L1 = 7;

    logic       CLK = 1'b0;
    logic       SCLR = 1'b1;
    logic       IN_DATA = 1'b0;
    logic       pdet0, pdet1;
    logic [4:0] loc0, loc1;
    logic [1:0] seq0, seq1;

    pattern_locater #(.PATTERN(P0), .FRAME_LEN(L0)) dut0 (
        .CLK(CLK), .SCLR(SCLR), .IN_DATA(IN_DATA), .PDET(pdet0), .LOC(loc0), .SEQ(seq0)
    );
    pattern_locater #(.PATTERN(P1), .FRAME_LEN(L1)) dut1 (
        .CLK(CLK), .SCLR(SCLR), .IN_DATA(IN_DATA), .PDET(pdet1), .LOC(loc1), .SEQ(seq1)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       pdet;
        logic [4:0] loc;
        logic [1:0] seq;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    bit   hist[$];
    int   mloc[2];
    int   mseq[2];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, got, exp);
        end
    endtask

    // Expected outputs for one instance after the bit just appended to hist
    task automatic predict(input int k, input logic [3:0] pat, input int flen, output exp_t e);
        int n;
        logic [3:0] win;
        logic hit;
        n   = hist.size();
        hit = 1'b0;
        if (n >= 4) begin
            win = {hist[n-4], hist[n-3], hist[n-2], hist[n-1]};
            hit = (win == pat);
        end
        if (hit) begin
            mloc[k] = (n - 1) % flen;
            mseq[k] = (mseq[k] + 1) % 4;
        end
        e.pdet = hit;
        e.loc  = 5'(mloc[k]);
        e.seq  = 2'(mseq[k]);
    endtask

    task automatic step(input logic s, input logic b);
        exp_t e0, e1;
        SCLR    = s;
        IN_DATA = b;
        if (s) begin
            hist.delete();
            mloc[0] = 0; mloc[1] = 0;
            mseq[0] = 0; mseq[1] = 0;
            e0 = '{1'b0, 5'd0, 2'd0};
            e1 = e0;
        end else begin
            hist.push_back(b);
            predict(0, P0, L0, e0);
            predict(1, P1, L1, e1);
        end
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge CLK);
        #1;
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) begin
            step(1'b0, s[i] == "1");
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        cyc++;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("pdet0", pdet0, e.pdet);
            chk("loc0", loc0, e.loc);
            chk("seq0", seq0, e.seq);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("pdet1", pdet1, e.pdet);
            chk("loc1", loc1, e.loc);
            chk("seq1", seq1, e.seq);
        end
    end

    initial begin
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);

        feed("0010110011010101100");

        step(1'b1, 1'b0);
        for (int f = 0; f < 4; f++) feed("10100000101000001110");

        step(1'b1, 1'b0);
        feed("0");
        for (int f = 0; f < 4; f++) feed("10100000101000001110");

        step(1'b1, 1'b0);
        feed("111");
        step(1'b1, 1'b0);
        feed("0");
        feed("1110");

        step(1'b1, 1'b0);
        feed("111");
        step(1'b1, 1'b0);
        feed("1");

        step(1'b1, 1'b0);
        feed("0000000000000000");
        feed("1000");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 79) == 0) step(1'b1, 1'($urandom_range(0, 1)));
            else if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0);
            else step(1'b0, 1'($urandom_range(0, 1)));
        end

        step(1'b0, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
